// File: rtl/module_alu_operand_loader_pkg.sv
// Shared types for the ALU operand loader: operand/result word and loader FSM states.
// Ports: none (package only).
// Imported by module_alu_operand_loader and its testbench.
package pkg_bits;

  localparam int BITS_W = 4;

  typedef logic [BITS_W-1:0] bits_t;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_SHOW = 2'd3
  } loader_state_t;

endpackage

// File: rtl/module_alu_operand_loader_edge_detect.sv
// Purpose: turns a debounced push-button level into a one-cycle pulse per rising edge.
// Ports: clk_i, rst_i (sync, active-high), level_i (button level), pulse_o (edge pulse).
// Latency: pulse_o is combinational from level_i against the previous sampled level.
module module_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;
  logic level_d;

  // The history register keeps tracking the button through reset, so a button
  // held across reset release does not fire until it is released and pressed again.
  always_comb begin
    level_d = level_i;
  end

  always_ff @(posedge clk_i) begin
    level_q <= level_d;
  end

  // No pulse is produced while reset is asserted.
  assign pulse_o = level_i & ~level_q & ~rst_i;

endmodule

// File: rtl/module_alu_operand_loader.sv
// Purpose: captures operand A, operand B + opcode on successive load presses, issues them
//   to the ALU for one cycle, then latches ALUResult/ALUFlags for display.
// Ports: clk_i/rst_i (sync active-high), data_i/op_i/load_i switches and button,
//   ALUResult_i/ALUFlags_i from the ALU, ALUA_o/ALUB_o/ALUControl_o to the ALU,
//   valid_o issue strobe, result_o/flags_o latched result, done_o show flag, state_o LEDs.
// Config: define LOADER_EDGE_DETECT_EN to treat load_i as a level and act once per rising edge;
//   otherwise load_i is taken as an already single-cycle pulse.
module module_alu_operand_loader
  import pkg_bits::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  bits_t          data_i,
  input  logic [OPW-1:0] op_i,
  input  logic           load_i,
  input  bits_t          ALUResult_i,
  input  logic           ALUFlags_i,
  output bits_t          ALUA_o,
  output bits_t          ALUB_o,
  output logic [OPW-1:0] ALUControl_o,
  output logic           valid_o,
  output bits_t          result_o,
  output logic           flags_o,
  output logic           done_o,
  output logic [1:0]     state_o
);

  logic ld;

`ifdef LOADER_EDGE_DETECT_EN
  module_edge_detect u_edge_detect (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .level_i (load_i),
    .pulse_o (ld)
  );
`else
  assign ld = load_i;
`endif

  loader_state_t  state_q,  state_d;
  bits_t          alua_q,   alua_d;
  bits_t          alub_q,   alub_d;
  logic [OPW-1:0] ctrl_q,   ctrl_d;
  bits_t          result_q, result_d;
  logic           flags_q,  flags_d;

  always_comb begin
    state_d  = state_q;
    alua_d   = alua_q;
    alub_d   = alub_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_A: begin
        if (ld) begin
          alua_d  = data_i;
          state_d = S_B;
        end
      end
      S_B: begin
        if (ld) begin
          alub_d  = data_i;
          ctrl_d  = op_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Single issue cycle: a load here is dropped, not remembered.
        result_d = ALUResult_i;
        flags_d  = ALUFlags_i;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        // One press starts the next operation by loading A directly.
        if (ld) begin
          alua_d  = data_i;
          state_d = S_B;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_A;
      alua_q   <= '0;
      alub_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flags_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alua_q   <= alua_d;
      alub_q   <= alub_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Status outputs decode the registered state only.
  assign valid_o      = (state_q == S_EXEC);
  assign done_o       = (state_q == S_SHOW);
  assign state_o      = state_q;
  assign ALUA_o       = alua_q;
  assign ALUB_o       = alub_q;
  assign ALUControl_o = ctrl_q;
  assign result_o     = result_q;
  assign flags_o      = flags_q;

endmodule

// File: tb/tb_module_alu_operand_loader.sv
module tb_module_alu_operand_loader;
  import pkg_bits::*;

  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst_i;
  bits_t          data_i;
  logic [OPW-1:0] op_i;
  logic           load_i;
  bits_t          alu_res;
  logic           alu_flg;
  bits_t          ALUA_o, ALUB_o, result_o;
  logic [OPW-1:0] ALUControl_o;
  logic           valid_o, flags_o, done_o;
  logic [1:0]     state_o;

  int total = 0;
  int bad   = 0;

  // OR ALU with zero flag, sitting downstream of the loader.
  assign alu_res = ALUA_o | ALUB_o;
  assign alu_flg = (alu_res == '0);

  always #5 clk = ~clk;

  module_alu_operand_loader #(.OPW(OPW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .op_i         (op_i),
    .load_i       (load_i),
    .ALUResult_i  (alu_res),
    .ALUFlags_i   (alu_flg),
    .ALUA_o       (ALUA_o),
    .ALUB_o       (ALUB_o),
    .ALUControl_o (ALUControl_o),
    .valid_o      (valid_o),
    .result_o     (result_o),
    .flags_o      (flags_o),
    .done_o       (done_o),
    .state_o      (state_o)
  );

  // Reference model: which step of the A / B / issue / show cycle we are in,
  // plus the values the user has entered so far.
  int             m_step;
  bits_t          m_a, m_b, m_res;
  logic [OPW-1:0] m_op;
  logic           m_flg;
  logic           m_prev_load;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = 1'b0;
  endtask

  // One clock: compare everything at the falling edge, advance the model
  // with the inputs the rising edge will see, then step past that edge.
  task automatic tick();
    logic press;
    @(negedge clk);
    check("state", state_o, m_step[1:0]);
    check("alua", ALUA_o, m_a);
    check("alub", ALUB_o, m_b);
    check("ctrl", ALUControl_o, m_op);
    check("valid", valid_o, m_step == 2);
    check("done", done_o, m_step == 3);
    check("result", result_o, m_res);
    check("flags", flags_o, m_flg);
`ifdef LOADER_EDGE_DETECT_EN
    press = load_i && !m_prev_load;
`else
    press = load_i;
`endif
    m_prev_load = load_i;
    if (rst_i) begin
      model_reset();
    end else if (m_step == 2) begin
      m_res  = m_a | m_b;
      m_flg  = (m_res == '0);
      m_step = 3;
    end else if (press) begin
      if (m_step == 1) begin
        m_b = data_i; m_op = op_i; m_step = 2;
      end else begin
        m_a = data_i; m_step = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bits_t d, input logic [OPW-1:0] op);
    data_i = d; op_i = op; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    tick();
  endtask

  bits_t saved_a;
  bits_t saved_res;

  initial begin
    rst_i = 1'b1; load_i = 1'b1; data_i = 4'h9; op_i = '0;
    m_prev_load = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    // Reset held with the button pressed.
    tick();
    tick();
    check("rst_a", ALUA_o, 0);
    check("rst_b", ALUB_o, 0);
    check("rst_ctrl", ALUControl_o, 0);
    check("rst_res", result_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_state", state_o, 0);
    rst_i = 1'b0;
`ifdef LOADER_EDGE_DETECT_EN
    // Button still held after release: nothing may be captured.
    tick();
    tick();
    check("rst_held_state", state_o, 0);
`endif
    load_i = 1'b0;
    tick();

    // Basic sequence with the OR ALU.
    press(4'h5, 4'h0);
    check("basic_a", ALUA_o, 4'h5);
    check("basic_state_b", state_o, 1);
    data_i = 4'hA; op_i = 4'h3; load_i = 1'b1;
    tick();
    load_i = 1'b0;
    check("basic_b", ALUB_o, 4'hA);
    check("basic_ctrl", ALUControl_o, 4'h3);
    check("basic_valid", valid_o, 1);
    tick();
    check("basic_valid_gone", valid_o, 0);
    check("basic_res", result_o, 4'hF);
    check("basic_done", done_o, 1);

    // Restart from SHOW: result holds until the next issue.
    press(4'h3, 4'h0);
    check("restart_a", ALUA_o, 4'h3);
    check("restart_state", state_o, 1);
    check("restart_res", result_o, 4'hF);

    // Load during the issue cycle is ignored.
    data_i = 4'h4; op_i = 4'h1; load_i = 1'b1;
    tick();
    saved_a = ALUA_o;
    data_i = 4'hC;
    tick();
    load_i = 1'b0;
    check("ign_state", state_o, 3);
    check("ign_a", ALUA_o, saved_a);
    tick();
    check("ign_novalid", valid_o, 0);
    check("ign_res", result_o, 4'h7);

    // Held button from S_A: 10 cycles end in S_B either way.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    data_i = 4'h2; load_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    load_i = 1'b0;
    check("held_state", state_o, 1);
    tick();

    // Reset mid-operation discards the partial capture.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    press(4'h7, 4'h0);
    check("mid_a7", ALUA_o, 4'h7);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_a0", ALUA_o, 0);
    check("mid_state", state_o, 0);
    press(4'h9, 4'h0);
    check("mid_reload_a", ALUA_o, 4'h9);
    check("mid_reload_state", state_o, 1);

    // Random traffic against the model.
    saved_res = result_o;
    for (int i = 0; i < 500; i++) begin
      rst_i  = ($urandom_range(0, 39) == 0);
      load_i = ($urandom_range(0, 9) < 4);
      data_i = bits_t'($urandom);
      op_i   = OPW'($urandom);
      tick();
    end
    rst_i = 1'b0; load_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stalled clock or run-away sequence.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
